// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) serial receiver.
package hamming_pkg;

  localparam int unsigned CW_W     = 7;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned ERRCNT_W = 16;
  localparam int unsigned CNT_W    = 3;

  // Syndrome {a,b,c} values that point at a data bit of the codeword.
  localparam logic [2:0] SYN_CW4 = 3'b110;
  localparam logic [2:0] SYN_CW2 = 3'b101;
  localparam logic [2:0] SYN_CW1 = 3'b011;
  localparam logic [2:0] SYN_CW0 = 3'b111;

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    DECODE = 2'd1,
    EMIT   = 2'd2
  } state_t;

endpackage

// File: rtl/hamming74_dec.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
module hamming74_dec
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]     cw,
  output logic [NIBBLE_W-1:0] nibble,
  output logic                syn_nz
);

  logic [2:0]      syn;
  logic [CW_W-1:0] fixed;

  // Compute syndrome and flip the data bit it points at; parity-bit hits leave data alone.
  always_comb begin
    syn   = {cw[6] ^ cw[4] ^ cw[2] ^ cw[0],
             cw[5] ^ cw[4] ^ cw[1] ^ cw[0],
             cw[3] ^ cw[2] ^ cw[1] ^ cw[0]};
    fixed = cw;
    case (syn)
      SYN_CW4: fixed[4] = ~cw[4];
      SYN_CW2: fixed[2] = ~cw[2];
      SYN_CW1: fixed[1] = ~cw[1];
      SYN_CW0: fixed[0] = ~cw[0];
      default: fixed = cw;
    endcase
    nibble = {fixed[4], fixed[2], fixed[1], fixed[0]};
    syn_nz = |syn;
  end

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Serial Hamming(7,4) receiver: shifts in codewords, decodes nibble pairs into bytes.
// Optional corrected-error counter enabled by defining HAMMING_ERRCNT_EN.
module hamming_rx_ctrl
  import hamming_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic        sync,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_err,
  output logic [15:0] err_cnt,
  input  logic        err_clr
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW_W - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      count;
  logic                  half;
  logic [CW_W-1:0]       cw;
  logic [NIBBLE_W-1:0]   hi_nib;
  logic [NIBBLE_W-1:0]   lo_nib;
  logic                  hi_err;
  logic                  lo_err;
  logic [NIBBLE_W-1:0]   dec_nibble;
  logic                  dec_syn_nz;
  logic                  accept;
  logic                  decode_en;
  logic                  load_out;

  hamming74_dec u_dec (
    .cw     (cw),
    .nibble (dec_nibble),
    .syn_nz (dec_syn_nz)
  );

  // State register; bit_ready is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SHIFT;
      bit_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_ready <= (state_nxt == SHIFT);
    end
  end

  // Next-state and datapath strobes; sync overrides every state.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    decode_en = 1'b0;
    load_out  = 1'b0;
    if (sync) begin
      state_nxt = SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          if (bit_valid) begin
            accept = 1'b1;
            if (count == LAST_CNT) state_nxt = DECODE;
          end
        end
        DECODE: begin
          decode_en = 1'b1;
          state_nxt = half ? EMIT : SHIFT;
        end
        EMIT: begin
          if (!byte_valid || byte_ready) begin
            load_out  = 1'b1;
            state_nxt = SHIFT;
          end
        end
        default: state_nxt = SHIFT;
      endcase
    end
  end

  // Codeword shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cw    <= '0;
      count <= '0;
    end else begin
      if (accept) cw <= {cw[CW_W-2:0], bit_in};
      if (sync) begin
        count <= '0;
      end else if (accept) begin
        count <= (count == LAST_CNT) ? '0 : count + CNT_W'(1);
      end
    end
  end

  // Nibble pairing: first decode fills the high half, second the low half.
  always_ff @(posedge clk) begin
    if (rst) begin
      half   <= 1'b0;
      hi_nib <= '0;
      hi_err <= 1'b0;
      lo_nib <= '0;
      lo_err <= 1'b0;
    end else if (sync) begin
      half   <= 1'b0;
      hi_nib <= '0;
      hi_err <= 1'b0;
    end else if (decode_en) begin
      half <= ~half;
      if (!half) begin
        hi_nib <= dec_nibble;
        hi_err <= dec_syn_nz;
      end else begin
        lo_nib <= dec_nibble;
        lo_err <= dec_syn_nz;
      end
    end
  end

  // Output register with valid/ready handshake; reload wins over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_out   <= '0;
      byte_err   <= 1'b0;
      byte_valid <= 1'b0;
    end else if (load_out) begin
      byte_out   <= {hi_nib, lo_nib};
      byte_err   <= hi_err | lo_err;
      byte_valid <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      byte_valid <= 1'b0;
    end
  end

`ifdef HAMMING_ERRCNT_EN
  // Saturating corrected-error counter; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (decode_en && dec_syn_nz && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Self-checking bench for hamming_rx_ctrl: directed scenarios plus a randomized stream.
module tb_hamming_rx_ctrl;

`ifdef HAMMING_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic        sync;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_err;
  logic [15:0] err_cnt;
  logic        err_clr;

  int errors = 0;
  int checks = 0;

  logic       acc;
  logic       hs;
  logic [7:0] hb;
  logic       he;

  hamming_rx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .sync       (sync),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_err   (byte_err),
    .err_cnt    (err_cnt),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs at a falling edge, note what the next rising edge will do, advance one cycle.
  task automatic step(input logic b, input logic bv, input logic s, input logic br);
    bit_in     = b;
    bit_valid  = bv;
    sync       = s;
    byte_ready = br;
    acc = bit_ready && bv && !s && !rst;
    hs  = byte_valid && br && !rst;
    hb  = byte_out;
    he  = byte_err;
    @(negedge clk);
  endtask

  task automatic idle(input logic br);
    step(1'b0, 1'b0, 1'b0, br);
  endtask

  task automatic send_cw(input logic [6:0] w, input logic br);
    logic ok;
    for (int i = 6; i >= 0; i--) begin
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        step(w[i], 1'b1, 1'b0, br);
        ok = acc;
      end
      if (!ok) check("bit_accept_timeout", 16'(ok), 16'd1);
    end
  endtask

  // Reference encoder: data {d3,d2,d1,d0} at cw4,cw2,cw1,cw0 with even parity in cw6,cw5,cw3.
  function automatic logic [6:0] enc(input logic [3:0] n);
    return {n[3] ^ n[2] ^ n[0], n[3] ^ n[1] ^ n[0], n[3],
            n[2] ^ n[1] ^ n[0], n[2], n[1], n[0]};
  endfunction

  // Reference decoder: nearest valid codeword (perfect code, so always within distance 1).
  function automatic logic [4:0] model_dec(input logic [6:0] w);
    logic [4:0] r;
    r = 5'd0;
    for (int n = 0; n < 16; n++) begin
      if ($countones(enc(4'(n)) ^ w) <= 1) r = {enc(4'(n)) != w, 4'(n)};
    end
    return r;
  endfunction

  initial begin
    logic [6:0]  words [20];
    logic [6:0]  wtmp;
    logic [6:0]  mcw;
    logic [3:0]  mhi;
    logic        mhe;
    logic        mhalf;
    logic [4:0]  r;
    logic [8:0]  expq [$];
    logic [8:0]  prev_out;
    logic [8:0]  e;
    logic        prev_stall;
    logic        b;
    logic        bv;
    logic        br;
    int          pos;
    int          nbits;
    int          merr;
    int          got;

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; sync = 1'b0;
    byte_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    idle(1'b0);
    idle(1'b0);
    check("rst_byte_valid", 16'(byte_valid), 16'd0);
    check("rst_byte_out", 16'(byte_out), 16'd0);
    check("rst_byte_err", 16'(byte_err), 16'd0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_bit_ready", 16'(bit_ready), 16'd1);
    rst = 1'b0;

    // Clean pair 0x33, 0x7F: byte 0xBF two cycles after the last bit.
    send_cw(7'h33, 1'b0);
    send_cw(7'h7F, 1'b0);
    check("lat_c0_valid", 16'(byte_valid), 16'd0);
    idle(1'b0);
    check("lat_c1_valid", 16'(byte_valid), 16'd0);
    idle(1'b0);
    check("lat_c2_valid", 16'(byte_valid), 16'd1);
    check("clean_byte", 16'(byte_out), 16'h00BF);
    check("clean_err", 16'(byte_err), 16'd0);
    idle(1'b1);
    check("consume_valid", 16'(byte_valid), 16'd0);

    // Corrected error in cw4 of the high nibble.
    send_cw(7'h23, 1'b0);
    send_cw(7'h00, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("corr_valid", 16'(byte_valid), 16'd1);
    check("corr_byte", 16'(byte_out), 16'h00B0);
    check("corr_err", 16'(byte_err), 16'd1);
    check("corr_err_cnt", err_cnt, ERRCNT_ON ? 16'd1 : 16'd0);
    idle(1'b1);

    // Back-pressure across two bytes: first held, FSM parks in EMIT.
    send_cw(7'h33, 1'b0);
    send_cw(7'h7F, 1'b0);
    send_cw(7'h7F, 1'b0);
    send_cw(7'h33, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    check("bp_hold_valid", 16'(byte_valid), 16'd1);
    check("bp_hold_byte", 16'(byte_out), 16'h00BF);
    check("bp_park_bit_ready", 16'(bit_ready), 16'd0);
    idle(1'b1);
    check("bp_reload_valid", 16'(byte_valid), 16'd1);
    check("bp_reload_byte", 16'(byte_out), 16'h00FB);
    check("bp_resume_bit_ready", 16'(bit_ready), 16'd1);
    idle(1'b1);
    check("bp_drain_valid", 16'(byte_valid), 16'd0);

    // Resync after 9 bits (sync with a concurrent bit drops that bit).
    send_cw(7'h33, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("sync_no_partial", 16'(byte_valid), 16'd0);
    send_cw(7'h7F, 1'b0);
    send_cw(7'h33, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("sync_valid", 16'(byte_valid), 16'd1);
    check("sync_byte", 16'(byte_out), 16'h00FB);
    idle(1'b1);

    // err_clr in the same cycle as an errored decode.
    check("pre_clr_err_cnt", err_cnt, ERRCNT_ON ? 16'd1 : 16'd0);
    send_cw(7'h23, 1'b0);
    err_clr = 1'b1;
    idle(1'b0);
    err_clr = 1'b0;
    check("clr_vs_inc_err_cnt", err_cnt, 16'd0);
    send_cw(7'h00, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("pre_rst_valid", 16'(byte_valid), 16'd1);
    check("pre_rst_byte", 16'(byte_out), 16'h00B0);

    // Reset mid-codeword with a byte waiting.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    check("midrst_valid", 16'(byte_valid), 16'd0);
    check("midrst_byte", 16'(byte_out), 16'd0);
    check("midrst_err", 16'(byte_err), 16'd0);
    check("midrst_err_cnt", err_cnt, 16'd0);
    send_cw(7'h23, 1'b0);
    send_cw(7'h7F, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("postrst_valid", 16'(byte_valid), 16'd1);
    check("postrst_byte", 16'(byte_out), 16'h00BF);
    check("postrst_err", 16'(byte_err), 16'd1);
    check("postrst_err_cnt", err_cnt, ERRCNT_ON ? 16'd1 : 16'd0);
    idle(1'b1);

    // Randomized stream against the reference model.
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) words[i] = 7'($urandom_range(127));
    pos = 0; nbits = 0; merr = 0; got = 0;
    mcw = '0; mhi = '0; mhe = 1'b0; mhalf = 1'b0;
    prev_stall = 1'b0; prev_out = '0;
    for (int c = 0; c < 4000 && !(pos == 140 && got == 10); c++) begin
      bv = (pos < 140) && ($urandom_range(3) != 0);
      wtmp = words[(pos < 140) ? pos / 7 : 0];
      b = bv ? wtmp[6 - (pos % 7)] : 1'b0;
      br = 1'($urandom_range(1));
      if (prev_stall) check("stall_stable", 16'({byte_err, byte_out}), 16'(prev_out));
      prev_stall = byte_valid && !br;
      prev_out = {byte_err, byte_out};
      step(b, bv, 1'b0, br);
      if (acc) begin
        mcw = {mcw[5:0], b};
        pos++;
        nbits++;
        if (nbits == 7) begin
          nbits = 0;
          r = model_dec(mcw);
          if (r[4] && merr < 65535) merr++;
          if (!mhalf) begin
            mhi = r[3:0];
            mhe = r[4];
            mhalf = 1'b1;
          end else begin
            expq.push_back({mhe | r[4], mhi, r[3:0]});
            mhalf = 1'b0;
          end
        end
      end
      if (hs) begin
        if (expq.size() == 0) begin
          check("rand_spurious_byte", 16'({he, hb}), 16'h0FFF);
        end else begin
          e = expq.pop_front();
          got++;
          check("rand_byte", 16'({he, hb}), 16'(e));
        end
      end
    end
    check("rand_all_bits_taken", 16'(pos), 16'd140);
    check("rand_all_bytes_seen", 16'(got), 16'd10);
    check("rand_err_cnt", err_cnt, ERRCNT_ON ? 16'(merr) : 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_rx_ctrl.md
HAMMING_RX_CTRL -- requirements
Module: hamming_rx_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL declare ports in this order: clk, rst, bit_in, bit_valid, bit_ready, sync, byte_out, byte_valid, byte_ready, byte_err, err_cnt, err_clr.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- bit_in  input  1  serial codeword bit, bit 6 first.
- bit_valid  input  1  bit_in valid.
- bit_ready  output  1  block accepts a bit this cycle.
- sync  input  1  frame resync pulse.
- byte_out  output  8  decoded byte.
- byte_valid  output  1  byte_out valid.
- byte_ready  input  1  consumer accepts byte.
- byte_err  output  1  either nibble of byte_out had a nonzero syndrome.
- err_cnt  output  16  corrected-error count (HAMMING_ERRCNT_EN only).
- err_clr  input  1  clear err_cnt (HAMMING_ERRCNT_EN only).

Function
REQ-003 SHALL accept a bit when bit_valid && bit_ready and shift it into a 7-bit codeword register cw[6:0], MSB first.
REQ-004 SHALL use FSM states SHIFT, DECODE, EMIT; bit_ready = 1 only in SHIFT.
REQ-005 SHIFT: 3-bit count 0..6; on acceptance of the 7th bit (count=6), count wraps to 0 and the next state is DECODE.
REQ-006 DECODE (one cycle): syndrome a=cw6^cw4^cw2^cw0, b=cw5^cw4^cw1^cw0, c=cw3^cw2^cw1^cw0; abc=110 flips cw4, 101 flips cw2, 011 flips cw1, 111 flips cw0; other nonzero syndromes leave data unchanged; nibble={cw4,cw2,cw1,cw0}.
REQ-007 DECODE: the first nibble of a pair is stored as the high nibble and the state returns to SHIFT; the second nibble is the low nibble and the state goes to EMIT.
REQ-008 EMIT: if !byte_valid || byte_ready, SHALL load byte_out/byte_err, set byte_valid, and go to SHIFT; otherwise SHALL stay in EMIT.
REQ-009 SHALL clear byte_valid on byte_valid && byte_ready unless it is reloaded in the same cycle.
REQ-010 Latency: with the output free, byte_valid SHALL rise 2 cycles after the cycle in which the 14th bit of a pair is accepted.
REQ-011 byte_out/byte_err SHALL be stable while byte_valid && !byte_ready.
REQ-012 sync SHALL clear the bit count, the half-byte flag and the pending high nibble, and force SHIFT; it SHALL NOT affect a byte already in the output register.
REQ-013 If sync and an accepted bit occur in the same cycle, sync SHALL win and the bit SHALL be dropped.
REQ-014 sync in DECODE or EMIT SHALL discard the in-flight nibble/byte.

Reset
REQ-015 On rst: state=SHIFT, count=0, half flag=0, cw=0, byte_out=0, byte_valid=0, byte_err=0, err_cnt=0.
REQ-016 rst SHALL take priority over sync, err_clr and all handshakes, including mid-codeword.

Configuration
REQ-017 With HAMMING_ERRCNT_EN defined, err_cnt SHALL increment by 1 in each DECODE cycle with a nonzero syndrome and saturate at 0xFFFF.
REQ-018 With HAMMING_ERRCNT_EN defined, err_clr SHALL zero err_cnt, and err_clr plus an increment in the same cycle SHALL yield 0.
REQ-019 Without HAMMING_ERRCNT_EN, err_cnt SHALL be tied to 0, err_clr SHALL be ignored, and no counter flops SHALL exist.

Structure
REQ-020 Package hamming_pkg SHALL hold: the state enum typedef, CW_W=7, NIBBLE_W=4, ERRCNT_W=16, and the syndrome constants 110/101/011/111.
REQ-021 The syndrome/correction logic SHALL be the combinational sub-module hamming74_dec (in cw[6:0]; out nibble[3:0], syn_nz), instantiated once.

Verification
REQ-022 Bits 0x33 then 0x7F, output free -> byte_out=0xBF, byte_err=0, byte_valid 2 cycles after the last bit.
REQ-023 Bits 0x23 (cw4 flipped) then 0x00 -> byte_out=0xB0, byte_err=1, err_cnt=1.
REQ-024 byte_ready held 0 across two complete bytes -> first byte held stable, FSM parks in EMIT, bit_ready=0; byte_ready=1 -> second byte loaded the next cycle.
REQ-025 sync after 9 bits, then 0x7F, 0x33 -> byte_out=0xFB; the partial data is never emitted.
REQ-026 err_cnt preloaded to 0xFFFF via errored codewords, then another error -> stays 0xFFFF; err_clr concurrent with an error -> 0.
REQ-027 rst asserted mid-codeword with byte_valid=1 -> all outputs 0 the next cycle; the following 14 bits decode correctly.
